sram_burst_master: RTL and testbench

- Burst initiator for the on-chip SRAM controller request/response handshake. It is the CPU-side end of that interface.
- Takes one burst command (base address, beat count, direction) and issues sequential word requests.
- Write bursts take write data from an input stream. Read bursts return data on an output stream in order.
- Sits between DMA/fetch logic and the SRAM controller.

---
 rtl/sram_pkg.sv | 10 +
 rtl/sram_outstanding_ctr.sv | 29 ++
 rtl/sram_burst_master.sv | 135 +++++++++++++
 tb/tb_sram_burst_master.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the SRAM burst master.
package sram_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} burst_state_e;

    function automatic int unsigned beat_bytes(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/sram_outstanding_ctr.sv
// Up/down counter of issued-but-unanswered SRAM requests.
module sram_outstanding_ctr #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && !dec)
            count <= count + CNT_W'(1);
        else if (dec && !inc)
            count <= count - CNT_W'(1);
    end

    assign full = (count == CNT_W'(MAX_OUTSTANDING));

    // A response with nothing in flight means the controller broke the protocol.
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) dec |-> (count != '0));
    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) (inc && !dec) |-> !full);

endmodule

// File: rtl/sram_burst_master.sv
// Burst initiator on the SRAM controller request/response handshake.
// Optional stall counter output enabled by SRAM_BURST_MASTER_PERF_EN.
module sram_burst_master
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic                    cmd_write,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wbe,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_resp_valid,
    output logic                    mem_resp_ready
`ifdef SRAM_BURST_MASTER_PERF_EN
    ,
    output logic [31:0]             stall_cycles
`endif
);

    localparam int BEAT  = beat_bytes(DATA_WIDTH);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    burst_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic                  write_q;
    logic                  done_burst_q, done_zero_q;
    logic [CNT_W-1:0]      outstanding;
    logic                  full;
    logic                  active, cmd_fire, req_fire, resp_fire;

    sram_outstanding_ctr #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .CNT_W          (CNT_W)
    ) u_ctr (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (req_fire),
        .dec  (resp_fire),
        .count(outstanding),
        .full (full)
    );

    assign active = (state_q != IDLE);

    // Block acceptance while a completed burst's done is showing.
    assign cmd_ready = (state_q == IDLE) && !done_burst_q;
    assign cmd_fire  = cmd_valid && cmd_ready;

    assign mem_req_valid = (state_q == ISSUE) && !full && (!write_q || wr_valid);
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wr_data;
    assign mem_wbe       = write_q ? wr_be : '0;
    assign wr_ready      = write_q && req_fire;

    assign mem_resp_ready = active && (write_q || rd_ready);
    assign rd_valid       = active && !write_q && mem_resp_valid;
    assign rd_data        = mem_rdata;
    assign resp_fire      = mem_resp_valid && mem_resp_ready;

    assign done = done_burst_q || done_zero_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_fire && cmd_len != '0) state_d = ISSUE;
            ISSUE:   if (req_fire && rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
            DRAIN:   if (outstanding == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            write_q      <= 1'b0;
            done_burst_q <= 1'b0;
            done_zero_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_zero_q  <= cmd_fire && (cmd_len == '0);
            done_burst_q <= (state_q == DRAIN) && (state_d == IDLE);
            if (cmd_fire) begin
                addr_q  <= cmd_addr;
                rem_q   <= cmd_len;
                write_q <= cmd_write;
            end else if (req_fire) begin
                addr_q <= addr_q + ADDR_WIDTH'(BEAT);
                rem_q  <= rem_q - LEN_WIDTH'(1);
            end
        end
    end

`ifdef SRAM_BURST_MASTER_PERF_EN
    // Request stall and read-output stall can coincide; both are counted.
    logic [1:0]  stall_inc;
    logic [32:0] stall_sum;

    assign stall_inc = 2'(mem_req_valid && !mem_req_ready) + 2'(rd_valid && !rd_ready);
    assign stall_sum = {1'b0, stall_cycles} + 33'(stall_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (cmd_fire)
            stall_cycles <= '0;
        else if (stall_inc != 2'd0)
            stall_cycles <= stall_sum[32] ? '1 : stall_sum[31:0];
    end
`endif

endmodule

// File: tb/tb_sram_burst_master.sv
// Randomized scoreboard bench for sram_burst_master with a behavioural SRAM controller.
`timescale 1ns/1ps
module tb_sram_burst_master;
    localparam int AW = 32, DW = 32, LW = 8, MO = 2;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          cmd_write, cmd_valid, cmd_ready;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_be;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_ready, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_wbe;
    logic          mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready;

    always #5 clk = ~clk;

    sram_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_write(cmd_write),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .wr_data(wr_data), .wr_be(wr_be), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .done(done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wbe(mem_wbe),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_rdata(mem_rdata), .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready)
    );

    typedef struct { logic [31:0] addr; logic [3:0] wbe; logic [31:0] wdata; } req_t;
    typedef struct { logic [31:0] data; logic [3:0] be; } wbeat_t;
    typedef struct { logic [31:0] addr; bit wr; int due; } pend_t;

    req_t        exp_req[$];
    logic [31:0] exp_rd[$];
    wbeat_t      wr_q[$];
    pend_t       pend_q[$];

    int total = 0, bad = 0;
    int lat_min = 2, lat_max = 2, req_ready_pct = 100, rd_ready_pct = 100;
    int rd_hold = 0, wr_gap = 0, cyc = 0;
    int exp_dones = 0, done_seen = 0, outs = 0;
    bit cur_write = 1'b0;

    // Memory contents the controller model returns for any address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5EED1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // SRAM controller model: in-order responses after a random latency.
    initial begin
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        forever begin
            bit rf, sf;
            logic [31:0] a;
            logic [3:0]  be;
            @(negedge clk);
            rf = mem_req_valid && mem_req_ready;
            sf = mem_resp_valid && mem_resp_ready;
            a  = mem_addr;
            be = mem_wbe;
            @(posedge clk); #1;
            cyc++;
            if (sf && pend_q.size() > 0) void'(pend_q.pop_front());
            if (rf && rst_n) pend_q.push_back('{a, (be != 4'b0), cyc + int'($urandom_range(lat_max, lat_min))});
            mem_req_ready = ($urandom_range(99, 0) < req_ready_pct);
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = pend_q[0].wr ? $urandom : mem_word(pend_q[0].addr);
            end else begin
                mem_resp_valid = 1'b0;
                mem_rdata      = $urandom;
            end
        end
    end

    initial begin
        rd_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rd_hold > 0) begin rd_hold--; rd_ready = 1'b0; end
            else rd_ready = ($urandom_range(99, 0) < rd_ready_pct);
        end
    end

    // Write source: gaps only start between beats, never under a pending request.
    initial begin
        wr_valid = 1'b0; wr_data = '0; wr_be = '0;
        forever begin
            bit wf;
            @(negedge clk);
            wf = wr_valid && wr_ready;
            @(posedge clk); #1;
            if (wf && wr_q.size() > 0) void'(wr_q.pop_front());
            if (wr_gap > 0 && (wf || !wr_valid)) begin
                wr_gap--;
                wr_valid = 1'b0;
            end else if (wr_q.size() > 0) begin
                wr_valid = 1'b1;
                wr_data  = wr_q[0].data;
                wr_be    = wr_q[0].be;
            end else begin
                wr_valid = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a transfer.
    initial begin
        forever begin
            bit rf, sf;
            int nxt;
            req_t e;
            @(negedge clk);
            if (rst_n) begin
                rf = mem_req_valid && mem_req_ready;
                sf = mem_resp_valid && mem_resp_ready;
                if (rf) begin
                    if (exp_req.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_req actual=%0h required=none", mem_addr);
                    end else begin
                        e = exp_req.pop_front();
                        check("req_addr", mem_addr, e.addr);
                        check("req_wbe", mem_wbe, e.wbe);
                        if (e.wbe != 4'b0) check("req_wdata", mem_wdata, e.wdata);
                    end
                end
                if (cur_write && mem_req_valid) check("req_valid_needs_wr_valid", wr_valid, 1);
                if (cur_write && sf) check("no_rd_on_write", rd_valid, 0);
                if (!cur_write && !rd_ready) check("resp_ready_follows_rd_ready", mem_resp_ready, 0);
                if (rd_valid && rd_ready) begin
                    if (exp_rd.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_rd actual=%0h required=none", rd_data);
                    end else check("rd_data", rd_data, exp_rd.pop_front());
                end
                if (rf || sf) begin
                    nxt = outs + int'(rf) - int'(sf);
                    if (nxt < 0 || nxt > MO) begin
                        total++; bad++;
                        $display("FAIL outstanding_range actual=%0d required=0..%0d", nxt, MO);
                    end
                    outs = nxt;
                end
                if (done) done_seen++;
            end
        end
    end

    task automatic send_cmd(input logic [31:0] a, input int len, input bit w,
                            input logic [3:0] be, input bit rand_be);
        bit ok;
        cur_write = w;
        for (int i = 0; i < len; i++) begin
            logic [31:0] ba;
            wbeat_t b;
            ba = a + 32'(i * 4);
            if (w) begin
                b.data = $urandom;
                b.be   = rand_be ? 4'($urandom_range(15, 1)) : be;
                wr_q.push_back(b);
                exp_req.push_back('{ba, b.be, b.data});
            end else begin
                exp_req.push_back('{ba, 4'b0, 32'h0});
                exp_rd.push_back(mem_word(ba));
            end
        end
        exp_dones++;
        @(posedge clk); #1;
        cmd_addr = a; cmd_len = LW'(len); cmd_write = w; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = cmd_ready;
        end
        if (!ok) fail_now("cmd_accept");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 2000 && !got; t++) begin
            @(negedge clk);
            got = done;
        end
        if (!got) fail_now(name);
        check("req_queue_drained", exp_req.size(), 0);
        check("rd_queue_drained", exp_rd.size(), 0);
    endtask

    task automatic check_reset_outs();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_mem_resp_ready", mem_resp_ready, 0);
        check("rst_done", done, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        cmd_addr = '0; cmd_len = '0; cmd_write = 1'b0; cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 check_reset_outs();
        rst_n = 1'b1;

        // read burst, fixed 2-cycle latency
        send_cmd(32'h100, 4, 1'b0, 4'b0, 1'b0);
        wait_done("read4_done");

        // write burst with fixed byte enables
        send_cmd(32'h200, 3, 1'b1, 4'b0011, 1'b0);
        wait_done("write3_done");

        // read output stalled for 10 cycles
        rd_hold = 10;
        send_cmd(32'h400, 3, 1'b0, 4'b0, 1'b0);
        wait_done("backpressure_done");

        // zero-length command
        send_cmd(32'h40, 0, 1'b0, 4'b0, 1'b0);
        @(negedge clk);
        check("len0_done", done, 1);
        check("len0_cmd_ready", cmd_ready, 1);
        check("len0_no_req", mem_req_valid, 0);
        @(negedge clk);
        check("len0_done_clear", done, 0);

        // address wrap
        send_cmd(32'hFFFF_FFFC, 2, 1'b0, 4'b0, 1'b0);
        wait_done("wrap_done");

        // write data gap mid-burst
        send_cmd(32'h600, 4, 1'b1, 4'b1111, 1'b0);
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            seen = wr_valid && wr_ready;
        end
        if (!seen) fail_now("gap_first_beat");
        wr_gap = 5;
        wait_done("gap_done");

        // randomized mix
        lat_min = 1; lat_max = 4; req_ready_pct = 70; rd_ready_pct = 70;
        for (int n = 0; n < 30; n++) begin
            logic [31:0] a;
            a = {$urandom} & 32'hFFFF_FFFC;
            send_cmd(a, int'($urandom_range(8, 0)), 1'($urandom_range(1, 0)), 4'b0, 1'b1);
            wait_done("rand_done");
        end

        // reset while one request is in flight
        lat_min = 6; lat_max = 6; req_ready_pct = 100; rd_ready_pct = 100;
        send_cmd(32'h800, 8, 1'b0, 4'b0, 1'b0);
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            seen = mem_req_valid && mem_req_ready;
        end
        if (!seen) fail_now("reset_first_req");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1 check_reset_outs();
        exp_dones--;
        repeat (2) @(posedge clk);
        exp_req.delete(); exp_rd.delete(); wr_q.delete(); pend_q.delete(); outs = 0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        lat_min = 2; lat_max = 2;
        send_cmd(32'h900, 3, 1'b1, 4'b1100, 1'b0);
        wait_done("post_reset_write_done");
        send_cmd(32'hA00, 3, 1'b0, 4'b0, 1'b0);
        wait_done("post_reset_read_done");

        repeat (3) @(negedge clk);
        check("done_count", done_seen, exp_dones);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
